// File: rtl/lafpm_pkg.sv
// Shared types and helpers for the logarithmic (Mitchell) FP stream multiplier.
package lafpm_pkg;

  // Controller states, one per datapath stage plus the two stream phases
  typedef enum logic [2:0] {
    ST_LOAD,
    ST_DECODE,
    ST_ADD,
    ST_NORM,
    ST_PACK,
    ST_SEND
  } state_t;

  // Operand classification; subnormals are folded into CLS_ZERO
  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } cls_t;

  // Number of BUS_W beats needed to carry one {sign, exponent, mantissa} word
  function automatic int nbeats(int exp_w, int man_w, int bus_w);
    return (1 + exp_w + man_w + bus_w - 1) / bus_w;
  endfunction

  // Exponent bias for an exp_w-bit field
  function automatic int bias(int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB only.
  // Returned zero-extended to 64 bits; callers keep the low 1+exp_w+man_w bits.
  function automatic logic [63:0] nan_enc(int exp_w, int man_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

  // Signed infinity: exponent all ones, mantissa zero.
  function automatic logic [63:0] inf_enc(logic sign, int exp_w, int man_w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[exp_w + man_w] = sign;
    return v;
  endfunction

endpackage

// File: rtl/lafpm_core.sv
// Decode / Mitchell-add / normalise / pack datapath of the log multiplier.
// Optional build macro: MITCHELL_CORR_EN adds mean-error compensation in the add stage.
module lafpm_core
  import lafpm_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   decode_en,
  input  logic                   add_en,
  input  logic                   norm_en,
  input  logic                   pack_en,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [2:0]             flags
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(bias(EXP_W));
  localparam logic signed [EXP_W+1:0] EMAX_S = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] ONE_S  = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] ZERO_S = (EXP_W+2)'(0);
  localparam logic [63:0] NAN_WIDE = nan_enc(EXP_W, MAN_W);
  localparam logic [63:0] INF_WIDE = inf_enc(1'b0, EXP_W, MAN_W);
  localparam logic [W-1:0] NAN_WORD = NAN_WIDE[W-1:0];
  localparam logic [W-1:0] INF_POS  = INF_WIDE[W-1:0];
`ifdef MITCHELL_CORR_EN
  localparam logic [MAN_W:0] CORR = (MAN_W+1)'(1) << (MAN_W - 4);
`endif

  // Decoded operand fields
  logic                    sa_reg, sb_reg;
  logic [EXP_W-1:0]        ea_reg, eb_reg;
  logic [MAN_W-1:0]        ma_reg, mb_reg;
  cls_t                    ca_reg, cb_reg;
  // Add / normalise stage registers
  logic                    sign_reg;
  logic [MAN_W:0]          sum_reg;
  logic signed [EXP_W+1:0] e_add_reg;
  logic signed [EXP_W+1:0] e_norm_reg;
  logic [MAN_W-1:0]        m_norm_reg;
  // Pack stage
  logic [W-1:0]            result_reg, result_next;
  logic [2:0]              flags_reg, flags_next;
  logic [MAN_W:0]          sum_next;
  logic signed [EXP_W+1:0] e_add_next;

  function automatic cls_t classify(logic [EXP_W-1:0] e, logic [MAN_W-1:0] m);
    if (e == '0)       return CLS_ZERO;
    else if (e == '1)  return (m == '0) ? CLS_INF : CLS_NAN;
    else               return CLS_NORM;
  endfunction

  // Split and classify both operands
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_reg <= 1'b0;  sb_reg <= 1'b0;
      ea_reg <= '0;    eb_reg <= '0;
      ma_reg <= '0;    mb_reg <= '0;
      ca_reg <= CLS_ZERO;
      cb_reg <= CLS_ZERO;
    end else if (decode_en) begin
      sa_reg <= a[W-1];
      sb_reg <= b[W-1];
      ea_reg <= a[W-2:MAN_W];
      eb_reg <= b[W-2:MAN_W];
      ma_reg <= a[MAN_W-1:0];
      mb_reg <= b[MAN_W-1:0];
      ca_reg <= classify(a[W-2:MAN_W], a[MAN_W-1:0]);
      cb_reg <= classify(b[W-2:MAN_W], b[MAN_W-1:0]);
    end
  end

  // Mitchell log-domain sum of mantissas and biased exponent sum
  always_comb begin
    sum_next = {1'b0, ma_reg} + {1'b0, mb_reg};
`ifdef MITCHELL_CORR_EN
    if (ma_reg != '0 && mb_reg != '0) sum_next = sum_next + CORR;
`endif
    e_add_next = $signed({2'b00, ea_reg}) + $signed({2'b00, eb_reg}) - BIAS_S;
  end

  // Register the add stage
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_reg  <= 1'b0;
      sum_reg   <= '0;
      e_add_reg <= '0;
    end else if (add_en) begin
      sign_reg  <= sa_reg ^ sb_reg;
      sum_reg   <= sum_next;
      e_add_reg <= e_add_next;
    end
  end

  // A carry out of the mantissa sum bumps the exponent; the fraction is the low bits either way
  always_ff @(posedge clk) begin
    if (rst) begin
      e_norm_reg <= '0;
      m_norm_reg <= '0;
    end else if (norm_en) begin
      e_norm_reg <= sum_reg[MAN_W] ? e_add_reg + ONE_S : e_add_reg;
      m_norm_reg <= sum_reg[MAN_W-1:0];
    end
  end

  // Special-case priority: invalid, infinity, zero, overflow, underflow, normal
  always_comb begin
    result_next = '0;
    flags_next  = 3'b000;
    if (ca_reg == CLS_NAN || cb_reg == CLS_NAN ||
        (ca_reg == CLS_INF && cb_reg == CLS_ZERO) ||
        (ca_reg == CLS_ZERO && cb_reg == CLS_INF)) begin
      result_next = NAN_WORD;
      flags_next  = 3'b100;
    end else if (ca_reg == CLS_INF || cb_reg == CLS_INF) begin
      result_next = INF_POS | {sign_reg, {(W-1){1'b0}}};
    end else if (ca_reg == CLS_ZERO || cb_reg == CLS_ZERO) begin
      result_next = {sign_reg, {(W-1){1'b0}}};
    end else if (e_norm_reg >= EMAX_S) begin
      result_next = INF_POS | {sign_reg, {(W-1){1'b0}}};
      flags_next  = 3'b010;
    end else if (e_norm_reg <= ZERO_S) begin
      result_next = {sign_reg, {(W-1){1'b0}}};
      flags_next  = 3'b001;
    end else begin
      result_next = {sign_reg, e_norm_reg[EXP_W-1:0], m_norm_reg};
    end
  end

  // Hold the packed result and flags for the whole send phase
  always_ff @(posedge clk) begin
    if (rst) begin
      result_reg <= '0;
      flags_reg  <= 3'b000;
    end else if (pack_en) begin
      result_reg <= result_next;
      flags_reg  <= flags_next;
    end
  end

  assign result = result_reg;
  assign flags  = flags_reg;

endmodule

// File: rtl/lafpm_stream_mul.sv
// Byte-serial (BUS_W-beat) Mitchell log floating-point multiplier with valid/ready streams.
// Optional build macro: MITCHELL_CORR_EN (mean-error compensation, see lafpm_core).
module lafpm_stream_mul
  import lafpm_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BUS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_a,
  input  logic [BUS_W-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic             out_last,
  output logic [2:0]       flags,
  output logic             busy
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int NBEATS = nbeats(EXP_W, MAN_W, BUS_W);
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  state_t                  state_reg, state_next;
  logic [BEAT_W-1:0]       beat_reg, beat_next;
  logic [W-1:0]            a_reg, b_reg;
  logic [W-1:0]            result;
  logic [NBEATS*BUS_W-1:0] res_pad;
  logic [NBEATS-1:0]       beat_hit;
  logic                    load_fire;

  assign load_fire = (state_reg == ST_LOAD) && in_valid;

  // One-hot select of the operand slice written by the current input beat
  generate
    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat_sel
      assign beat_hit[gi] = load_fire && (beat_reg == BEAT_W'(gi));
    end
  endgenerate

  // State and beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_LOAD;
      beat_reg  <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
    end
  end

  // Capture operand beats; bits past the word width are simply never stored
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (beat_hit[i / BUS_W]) begin
          a_reg[i] <= in_a[i % BUS_W];
          b_reg[i] <= in_b[i % BUS_W];
        end
      end
    end
  end

  // Next-state, beat sequencing and stream outputs
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    res_pad    = '0;
    res_pad[W-1:0] = result;
    unique case (state_reg)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (beat_reg == LAST_BEAT) begin
            beat_next  = '0;
            state_next = ST_DECODE;
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      ST_DECODE: state_next = ST_ADD;
      ST_ADD:    state_next = ST_NORM;
      ST_NORM:   state_next = ST_PACK;
      ST_PACK:   state_next = ST_SEND;
      ST_SEND: begin
        out_valid = 1'b1;
        out_last  = (beat_reg == LAST_BEAT);
        out_data  = res_pad[beat_reg*BUS_W +: BUS_W];
        if (out_ready) begin
          if (beat_reg == LAST_BEAT) begin
            beat_next  = '0;
            state_next = ST_LOAD;
          end else begin
            beat_next = beat_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_LOAD;
        beat_next  = '0;
      end
    endcase
  end

  assign busy = (state_reg != ST_LOAD) || (beat_reg != '0);

  lafpm_core #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .decode_en(state_reg == ST_DECODE),
    .add_en   (state_reg == ST_ADD),
    .norm_en  (state_reg == ST_NORM),
    .pack_en  (state_reg == ST_PACK),
    .a        (a_reg),
    .b        (b_reg),
    .result   (result),
    .flags    (flags)
  );

endmodule

// File: tb/tb_lafpm_stream_mul.sv
// Randomised + directed bench for lafpm_stream_mul (default FP16, 8-bit beats).
module tb_lafpm_stream_mul;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [2:0] flags;
  logic       busy;

  int total = 0;
  int bad   = 0;
  bit rand_ready = 1'b0;

  typedef struct { logic [15:0] res; logic [2:0] fl; } exp_t;
  exp_t exp_q[$];
  int   mbeat = 0;

  always #5 clk = ~clk;

  lafpm_stream_mul dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .flags(flags), .busy(busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Reference: FP16 Mitchell product from the field-level rules, {flags, word}
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, s, e, corr;
    bit sign, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [4:0] e5;
    logic [9:0] m10;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    ma = int'(a[9:0]);   mb = int'(b[9:0]);
    sign   = a[15] ^ b[15];
    nan_a  = (ea == 31) && (ma != 0);  nan_b  = (eb == 31) && (mb != 0);
    inf_a  = (ea == 31) && (ma == 0);  inf_b  = (eb == 31) && (mb == 0);
    zero_a = (ea == 0);                zero_b = (eb == 0);
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) return {3'b100, 16'h7E00};
    if (inf_a || inf_b)   return {3'b000, sign, 15'h7C00};
    if (zero_a || zero_b) return {3'b000, sign, 15'h0000};
    corr = 0;
`ifdef MITCHELL_CORR_EN
    if (ma != 0 && mb != 0) corr = 64;
`endif
    s = (ma + mb + corr) % 2048;
    e = ea + eb - 15;
    if (s >= 1024) begin
      e = e + 1;
      s = s - 1024;
    end
    if (e >= 31) return {3'b010, sign, 15'h7C00};
    if (e <= 0)  return {3'b001, sign, 15'h0000};
    e5  = 5'(e);
    m10 = 10'(s);
    return {3'b000, sign, e5, m10};
  endfunction

  // Compare process: every cycle a result beat is presented, check it against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mbeat = 0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t cur;
        logic [15:0] sh;
        cur = exp_q[0];
        sh  = cur.res >> (8 * mbeat);
        check("out_data", 32'(out_data), 32'(sh[7:0]));
        check("out_last", 32'(out_last), 32'(mbeat == 1));
        check("flags", 32'(flags), 32'(cur.fl));
        check("in_ready_in_send", 32'(in_ready), 32'd0);
        if (out_ready) begin
          if (mbeat == 1) begin
            void'(exp_q.pop_front());
            mbeat = 0;
          end else begin
            mbeat++;
          end
        end
      end
    end
  end

  // Optional random backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_op(input logic [15:0] a, input logic [15:0] b, input bit gaps);
    logic [18:0] m;
    for (int k = 0; k < 2; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_a = 8'($urandom);
          in_b = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_a = (k == 0) ? a[7:0] : a[15:8];
      in_b = (k == 0) ? b[7:0] : b[15:8];
      @(negedge clk);
      check("in_ready_load", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
    end
    m = model(a, b);
    exp_q.push_back('{res: m[15:0], fl: m[18:16]});
  endtask

  // Count cycles from the final input handshake to the first result beat
  task automatic wait_first();
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("busy_compute", 32'(busy), 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd5);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 32'(n < 300), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_flags"}, 32'(flags), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  logic [15:0] dir_a [10] = '{16'h3C00, 16'h3E00, 16'hBC00, 16'h7800, 16'h0400,
                              16'h7C00, 16'h7C00, 16'h0000, 16'h7E01, 16'h4200};
  logic [15:0] dir_b [10] = '{16'h3C00, 16'h3E00, 16'h3C00, 16'h7800, 16'h0400,
                              16'h0000, 16'hC000, 16'hBC00, 16'h3C00, 16'hC500};

  initial begin
    logic [15:0] ra, rb;
    logic [15:0] exp_3e;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;

    // Pin the model to hand-computed values
`ifdef MITCHELL_CORR_EN
    exp_3e = 16'h4040;
`else
    exp_3e = 16'h4000;
`endif
    check("model_1x1", 32'(model(16'h3C00, 16'h3C00)), 32'h0_3C00);
    check("model_1.5sq", 32'(model(16'h3E00, 16'h3E00)), {13'd0, 3'b000, exp_3e});
    check("model_neg", 32'(model(16'hBC00, 16'h3C00)), 32'h0_BC00);
    check("model_ovf", 32'(model(16'h7800, 16'h7800)), 32'h2_7C00);
    check("model_unf", 32'(model(16'h0400, 16'h0400)), 32'h1_0000);
    check("model_inf_zero", 32'(model(16'h7C00, 16'h0000)), 32'h4_7E00);
    check("model_inf_neg", 32'(model(16'h7C00, 16'hC000)), 32'h0_FC00);
    check("model_zero_neg", 32'(model(16'h0000, 16'hBC00)), 32'h0_8000);

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // Directed vectors, no backpressure
    for (int i = 0; i < 10; i++) begin
      send_op(dir_a[i], dir_b[i], 1'b0);
      wait_first();
      wait_drain();
    end

    // Backpressure in SEND, with ignored input activity
    out_ready = 1'b0;
    send_op(16'h7800, 16'h7800, 1'b0);
    wait_first();
    in_valid = 1'b1;
    in_a = 8'hA5; in_b = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'h00);
      check("bp_flags", 32'(flags), 32'(3'b010));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Reset after the first input beat discards the partial operand
    in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("rst_load");
    rst = 1'b0;
    send_op(16'h3C00, 16'h3C00, 1'b1);
    wait_first();
    wait_drain();

    // Reset in the middle of SEND
    out_ready = 1'b0;
    send_op(16'h4200, 16'h4500, 1'b0);
    wait_first();
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("rst_send");
    rst = 1'b0;
    out_ready = 1'b1;
    send_op(16'h3C00, 16'h3C00, 1'b0);
    wait_first();
    wait_drain();

    // Random operands, random input gaps, random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 120; i++) begin
      for (int j = 0; j < 2; j++) begin
        int r, e, m;
        r = int'($urandom_range(0, 9));
        e = (r == 0) ? 0 : (r == 1) ? 31 : (r == 2) ? 1 : (r == 3) ? 30 : int'($urandom_range(1, 30));
        m = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023));
        if (j == 0) ra = {1'($urandom), 5'(e), 10'(m)};
        else        rb = {1'($urandom), 5'(e), 10'(m)};
      end
      send_op(ra, rb, 1'b1);
      wait_first();
      wait_drain();
    end
    rand_ready = 1'b0;
    #2;
    out_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
